// File: rtl/upsp_sched_pkg.sv
// Shared types and elaboration helpers for the upsampling output scheduler.
package upsp_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_e;

  function automatic int seg_width(input int dst_w, input int n);
    return dst_w / n;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered AXI-Stream stage carrying data, last and user.
// Accepts a new beat whenever it is empty or being popped in the same cycle.
module axis_reg_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  input  logic          s_user,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          m_user
);

  assign s_ready = ~m_valid | m_ready;

  // Slice register: load on accept, clear on pop without load, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_user  <= 1'b0;
    end else if (s_valid && s_ready) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_last  <= s_last;
      m_user  <= s_user;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_user  <= 1'b0;
    end
  end

endmodule

// File: rtl/upsp_out_scheduler.sv
// Grants the upsampling engines in strict raster order onto one AXI-Stream
// output, tagging row end / frame start and signalling frame completion.
module upsp_out_scheduler
  import upsp_sched_pkg::*;
#(
  parameter int N_PARALLEL         = 4,
  parameter int UPSP_WRTDATA_WIDTH = 24,
  parameter int DST_IMG_WIDTH      = 3840,
  parameter int DST_IMG_HEIGHT     = 2160
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     sched_start,
  input  logic [N_PARALLEL-1:0]                    upsp_wvalid,
  input  logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0] upsp_wdata,
  output logic [N_PARALLEL-1:0]                    upsp_wready,
  output logic                                     m_axis_tvalid,
  output logic [UPSP_WRTDATA_WIDTH-1:0]            m_axis_tdata,
  output logic                                     m_axis_tlast,
  output logic                                     m_axis_tuser,
  input  logic                                     m_axis_tready,
  output logic                                     sched_busy,
  output logic                                     sched_done,
  output logic [idx_width(N_PARALLEL)-1:0]         sched_gnt
);

  localparam int SEG = seg_width(DST_IMG_WIDTH, N_PARALLEL);
  localparam int GW  = idx_width(N_PARALLEL);
  localparam int CW  = idx_width(SEG);
  localparam int RW  = idx_width(DST_IMG_HEIGHT);
  localparam int W   = UPSP_WRTDATA_WIDTH;

  localparam logic [GW-1:0] GNT_LAST = GW'(N_PARALLEL - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SEG - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DST_IMG_HEIGHT - 1);

  if ((DST_IMG_WIDTH % N_PARALLEL) != 0) begin : g_width_chk
    $error("DST_IMG_WIDTH must be divisible by N_PARALLEL");
  end

  sched_state_e   state_r;
  sched_state_e   state_nxt_s;
  logic [GW-1:0]  gnt_r;
  logic [CW-1:0]  col_r;
  logic [RW-1:0]  row_r;
  logic           busy_r;
  logic           slice_ready_s;
  logic           load_s;
  logic           beat_last_s;
  logic           beat_user_s;
  logic           frame_end_s;
  logic           done_s;
  logic [W-1:0]   pix_s;

  // Granted-engine pixel mux, ready decode and beat tagging.
  always_comb begin
    pix_s       = '0;
    upsp_wready = '0;
    for (int i = 0; i < N_PARALLEL; i++) begin
      if (gnt_r == GW'(i)) begin
        pix_s = upsp_wdata[i*W +: W];
      end else begin
        pix_s = pix_s;
      end
    end
    if ((state_r == S_RUN) && slice_ready_s) begin
      upsp_wready[gnt_r] = 1'b1;
    end else begin
      upsp_wready = '0;
    end
    load_s      = upsp_wvalid[gnt_r] & upsp_wready[gnt_r];
    beat_last_s = (gnt_r == GNT_LAST) && (col_r == COL_LAST);
    beat_user_s = (row_r == '0) && (gnt_r == '0) && (col_r == '0);
    frame_end_s = beat_last_s && (row_r == ROW_LAST);
  end

  // Next-state logic; done is the pop of the final beat while draining.
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (sched_start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (load_s && frame_end_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (m_axis_tvalid && m_axis_tready) begin
          state_nxt_s = S_IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
    end
  end

  // Raster position: column within stripe, then engine, then row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      gnt_r <= '0;
      row_r <= '0;
    end else if ((state_r == S_IDLE) && sched_start) begin
      col_r <= '0;
      gnt_r <= '0;
      row_r <= '0;
    end else if (load_s) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        if (gnt_r == GNT_LAST) begin
          gnt_r <= '0;
          if (row_r == ROW_LAST) begin
            row_r <= '0;
          end else begin
            row_r <= row_r + RW'(1);
          end
        end else begin
          gnt_r <= gnt_r + GW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  axis_reg_slice #(
    .DW (W)
  ) u_out_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (load_s),
    .s_ready (slice_ready_s),
    .s_data  (pix_s),
    .s_last  (beat_last_s),
    .s_user  (beat_user_s),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (m_axis_tdata),
    .m_last  (m_axis_tlast),
    .m_user  (m_axis_tuser)
  );

  assign sched_busy = busy_r;
  assign sched_done = done_s;
  assign sched_gnt  = gnt_r;

endmodule

// File: tb/tb_upsp_out_scheduler.sv
// Scoreboard bench for upsp_out_scheduler with 2 engines, 8x2 frame, 8-bit pixels.
module tb_upsp_out_scheduler;

  localparam int N = 2;
  localparam int W = 8;
  localparam int BEATS = 16;

  logic           clk;
  logic           rst_n;
  logic           sched_start;
  logic [N-1:0]   upsp_wvalid;
  logic [N*W-1:0] upsp_wdata;
  logic [N-1:0]   upsp_wready;
  logic           m_axis_tvalid;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic           m_axis_tready;
  logic           sched_busy;
  logic           sched_done;
  logic [0:0]     sched_gnt;

  upsp_out_scheduler #(
    .N_PARALLEL         (N),
    .UPSP_WRTDATA_WIDTH (W),
    .DST_IMG_WIDTH      (8),
    .DST_IMG_HEIGHT     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sched_start   (sched_start),
    .upsp_wvalid   (upsp_wvalid),
    .upsp_wdata    (upsp_wdata),
    .upsp_wready   (upsp_wready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .sched_busy    (sched_busy),
    .sched_done    (sched_done),
    .sched_gnt     (sched_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  exp_q[$];
  int          ptr[N];
  int          hs_frame, out_frame, done_cnt;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  logic [N-1:0] eng_en;
  int          rdy_mode = 0;
  logic [3:0]  rdy_pat = 4'b1001;
  logic        start_s = 1'b0;
  logic        exp_busy = 1'b0;
  logic        held_v = 1'b0;
  logic [9:0]  held;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    logic [9:0] cur;
    logic       busy_before;
    int         exp_eng;
    @(negedge clk);
    cyc++;
    sched_start   = start_s;
    m_axis_tready = (rdy_mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
    for (int i = 0; i < N; i++) begin
      upsp_wvalid[i]       = eng_en[i] && (ptr[i] < 8);
      upsp_wdata[i*W +: W] = 8'(i * 16 + ptr[i]);
    end
    #1;
    busy_before = exp_busy;
    cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    chk("busy", {31'd0, sched_busy}, {31'd0, exp_busy});
    if (held_v) chk("stall_stable", {21'd0, m_axis_tvalid, cur}, {21'd0, 1'b1, held});
    held_v = m_axis_tvalid & ~m_axis_tready;
    held   = cur;
    chk("eng1_blocked", {31'd0, upsp_wready[1] & ((hs_frame % 8) < 4)}, 32'd0);
    chk("wready_onehot", ($countones(upsp_wready) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("beat", {22'd0, cur}, {22'd0, exp_q.pop_front()});
      end
      out_frame++;
    end
    if (sched_done) begin
      done_cnt++;
      chk("done_on_last", out_frame, BEATS);
      if (rdy_mode == 0) chk("done_latency", cyc - last_hs_cyc, 32'd1);
      exp_busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (upsp_wvalid[i] && upsp_wready[i]) begin
        exp_eng = (hs_frame % 8) / 4;
        chk("gnt_order", i, exp_eng);
        chk("sched_gnt", {31'd0, sched_gnt}, exp_eng);
        exp_q.push_back({(hs_frame == 0) ? 1'b1 : 1'b0,
                         ((hs_frame % 8) == 7) ? 1'b1 : 1'b0,
                         upsp_wdata[i*W +: W]});
        ptr[i]++;
        hs_frame++;
        last_hs_cyc = cyc;
      end
    end
    if (start_s && !busy_before) exp_busy = 1'b1;
    start_s = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) ptr[i] = 0;
    hs_frame = 0;
    out_frame = 0;
    done_cnt = 0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("abort_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("abort_tlast_tuser", {30'd0, m_axis_tlast, m_axis_tuser}, 32'd0);
    chk("abort_wready", {30'd0, upsp_wready}, 32'd0);
    chk("abort_busy", {31'd0, sched_busy}, 32'd0);
    chk("abort_gnt", {31'd0, sched_gnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, sched_done}, 32'd0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    exp_busy = 1'b0;
    held_v = 1'b0;
    clear_model();
  endtask

  // Runs one frame from a start pulse until done, with optional disturbances.
  task automatic run_frame(input bit restart, input bit late0, input int abort_at);
    int budget;
    bit did;
    clear_model();
    eng_en  = late0 ? 2'b10 : 2'b11;
    start_s = 1'b1;
    budget  = 0;
    did     = 1'b0;
    while (done_cnt == 0 && budget < 300) begin
      if (restart && !did && hs_frame == 5) begin
        start_s = 1'b1;
        did = 1'b1;
      end
      if (late0 && budget == 6) eng_en[0] = 1'b1;
      tick();
      budget++;
      if (abort_at > 0 && hs_frame >= abort_at) begin
        do_abort();
        return;
      end
    end
    if (done_cnt == 0) chk("frame_timeout", 32'd0, 32'd1);
    chk("frame_beats", out_frame, BEATS);
    chk("sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sched_start = 1'b0;
    upsp_wvalid = '0;
    upsp_wdata = '0;
    m_axis_tready = 1'b0;
    eng_en = 2'b11;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("reset_busy_done", {30'd0, sched_busy, sched_done}, 32'd0);
    chk("reset_gnt", {31'd0, sched_gnt}, 32'd0);
    rst_n = 1'b1;

    // Free-flowing frame, then idle cycles to confirm a single done pulse.
    rdy_mode = 0;
    run_frame(1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("done_once", done_cnt, 32'd1);

    // Engine 0 arrives late while engine 1 waits.
    run_frame(1'b0, 1'b1, 0);

    // Downstream backpressure pattern 1,0,0,1.
    rdy_mode = 1;
    run_frame(1'b0, 1'b0, 0);

    // Spurious start mid-frame.
    rdy_mode = 0;
    run_frame(1'b1, 1'b0, 0);

    // Reset after beat 6, then a clean frame.
    run_frame(1'b0, 1'b0, 6);
    run_frame(1'b0, 1'b0, 0);

    // Back-to-back frames, second start the cycle after done.
    run_frame(1'b0, 1'b0, 0);
    run_frame(1'b0, 1'b0, 0);
    for (int k = 0; k < 2; k++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
